// File: rtl/mic_frame_scheduler_pkg.sv
// Shared types and helpers for the microphone frame scheduler.
package mic_pkg;

    localparam int SAMP_W = 18;
    localparam int NSAMP  = 16;
    localparam int PEAK_W = SAMP_W - 1;

    typedef logic signed [SAMP_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SCAN,
        HOLD
    } sched_state_t;

    localparam sample_t            SAMP_MIN = {1'b1, {(SAMP_W-1){1'b0}}};
    localparam logic [PEAK_W-1:0]  PEAK_MAX = '1;

    // Magnitude of a signed sample; the most negative code has no positive
    // twin in SAMP_W bits, so it clips to the largest representable magnitude.
    function automatic logic [PEAK_W-1:0] abs_sat(sample_t x);
        sample_t mag;
        if (x == SAMP_MIN) begin
            return PEAK_MAX;
        end
        mag = x[SAMP_W-1] ? -x : x;
        return mag[PEAK_W-1:0];
    endfunction

endpackage

// File: rtl/mic_frame_scheduler_if.sv
// Frame hand-off channel from the scheduler to the display/FFT consumer.
interface mic_frame_scheduler_if;
    import mic_pkg::*;

    logic                    frm_valid;
    logic                    frm_ready;
    logic [NSAMP*SAMP_W-1:0] frm_data;
    logic [PEAK_W-1:0]       frm_peak;

    modport master (
        output frm_valid,
        output frm_data,
        output frm_peak,
        input  frm_ready
    );

    modport slave (
        input  frm_valid,
        input  frm_data,
        input  frm_peak,
        output frm_ready
    );

endinterface

// File: rtl/mic_frame_scheduler_abs_peak.sv
// Saturating absolute value and running maximum over the samples of a frame.
module mic_abs_peak
    import mic_pkg::*;
(
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  sample_t           sample,
    output logic [PEAK_W-1:0] peak
);

    logic [PEAK_W-1:0] mag;

    assign mag = abs_sat(sample);

    // Running maximum; clr restarts it at the beginning of each frame.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (clr) begin
            peak <= '0;
        end else if (en && (mag > peak)) begin
            peak <= mag;
        end
    end

endmodule

// File: rtl/mic_frame_scheduler.sv
// Frame-rate sequencer for mic_sampler: start pulse, done wait with timeout,
// sample snapshot, peak scan and valid/ready hand-off to the consumer.
//
//  state | meaning
//  IDLE  | waiting for a frame tick
//  START | one-cycle start pulse to mic_sampler, WAIT timer cleared
//  WAIT  | waiting for a fresh rising edge of smp_done, or timeout
//  SCAN  | one sample per cycle into the peak tracker
//  HOLD  | frame presented, waiting for frm_ready
module mic_frame_scheduler
    import mic_pkg::*;
#(
    parameter int FRAME_PERIOD = 416_667,
    parameter int TIMEOUT      = 65_535
) (
    input  logic                    clk_25,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic                    smp_start,
    input  logic                    smp_done,
    input  logic [NSAMP*SAMP_W-1:0] smp_data,
    mic_frame_scheduler_if.master   frm,
    output logic [7:0]              drop_cnt,
    output logic                    err_timeout
);

    localparam int PCNT_W = $clog2(FRAME_PERIOD);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int IDX_W  = $clog2(NSAMP);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(FRAME_PERIOD - 1);
    // Abort when the timer would reach TIMEOUT, so WAIT lasts at most TIMEOUT cycles.
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NSAMP - 1);

    sched_state_t            state_q;
    sched_state_t            state_d;
    logic [PCNT_W-1:0]       period_cnt;
    logic                    tick;
    logic [TMR_W-1:0]        wait_tmr;
    logic                    done_q;
    logic                    done_edge;
    logic [NSAMP*SAMP_W-1:0] frame_q;
    logic [IDX_W-1:0]        scan_idx;
    sample_t                 cur_sample;
    logic                    latch;
    logic                    scan_en;
    logic                    timeout_hit;
    logic                    frm_valid_c;

    assign tick       = enable && (period_cnt == PCNT_LAST);
    assign done_edge  = smp_done && !done_q;
    assign cur_sample = frame_q[scan_idx*SAMP_W +: SAMP_W];

    assign frm.frm_valid = frm_valid_c;
    assign frm.frm_data  = frame_q;

    // Frame-rate divider; held at zero while ticks are disabled.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (!enable || (period_cnt == PCNT_LAST)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PCNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d     = state_q;
        smp_start   = 1'b0;
        frm_valid_c = 1'b0;
        latch       = 1'b0;
        scan_en     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = START;
                end
            end
            START: begin
                smp_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (done_edge) begin
                    latch   = 1'b1;
                    state_d = SCAN;
                end else if (wait_tmr == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                if (scan_idx == IDX_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                frm_valid_c = 1'b1;
                if (frm.frm_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // WAIT timer, cleared while issuing the start pulse.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wait_tmr <= '0;
        end else if (state_q == START) begin
            wait_tmr <= '0;
        end else if (state_q == WAIT) begin
            wait_tmr <= wait_tmr + TMR_W'(1);
        end
    end

    // Done history for edge detection; a level already high in WAIT is not an edge.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= smp_done;
        end
    end

    // Snapshot of the sampler output and scan index.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            frame_q  <= '0;
            scan_idx <= '0;
        end else if (latch) begin
            frame_q  <= smp_data;
            scan_idx <= '0;
        end else if (scan_en) begin
            scan_idx <= scan_idx + IDX_W'(1);
        end
    end

    // Overrun counter and sticky timeout flag.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (tick && (state_q != IDLE) && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    mic_abs_peak u_abs_peak (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .clr    (latch),
        .en     (scan_en),
        .sample (cur_sample),
        .peak   (frm.frm_peak)
    );

endmodule

// File: tb/tb_mic_frame_scheduler.sv
// Directed bench for mic_frame_scheduler with a sampler model and a frame scoreboard.
module tb_mic_frame_scheduler;
    import mic_pkg::*;

    localparam int DW = NSAMP * SAMP_W;

    typedef struct {
        logic [DW-1:0]     data;
        logic [PEAK_W-1:0] peak;
    } sb_t;

    logic          clk_25;
    logic          rst_n;
    logic          enable;
    logic          smp_start;
    logic          smp_done;
    logic [DW-1:0] smp_data;
    logic [7:0]    drop_cnt;
    logic          err_timeout;

    mic_frame_scheduler_if bus ();

    mic_frame_scheduler #(
        .FRAME_PERIOD (64),
        .TIMEOUT      (100)
    ) dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .enable      (enable),
        .smp_start   (smp_start),
        .smp_done    (smp_done),
        .smp_data    (smp_data),
        .frm         (bus.master),
        .drop_cnt    (drop_cnt),
        .err_timeout (err_timeout)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic          respond = 1'b1;
    logic [DW-1:0] pat     = '0;
    sb_t           sb_q[$];

    initial begin
        clk_25 = 1'b0;
        forever #5 clk_25 = ~clk_25;
    end

    always @(posedge clk_25) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic logic [PEAK_W-1:0] exp_peak(input logic [DW-1:0] d);
        int m;
        int v;
        logic signed [SAMP_W-1:0] s;
        m = 0;
        for (int i = 0; i < NSAMP; i++) begin
            s = d[i*SAMP_W +: SAMP_W];
            v = s;
            if (v < 0) v = -v;
            if (v > 131071) v = 131071;
            if (v > m) m = v;
        end
        return PEAK_W'(m);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = smp_start, 1 = frm_valid, 2 = err_timeout
    task automatic wait_sig(input int sel, input string tag, output int c);
        logic hit;
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_25);
            case (sel)
                0:       hit = smp_start;
                1:       hit = bus.frm_valid;
                default: hit = err_timeout;
            endcase
            if (hit) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check({tag, "_wait_expired"}, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk_25);
        rst_n         = 1'b0;
        enable        = 1'b0;
        bus.frm_ready = 1'b0;
        respond       = 1'b1;
        sb_q.delete();
        repeat (3) @(negedge clk_25);
        rst_n = 1'b1;
    endtask

    task automatic ramp_pattern();
        pat = '0;
        for (int i = 0; i < NSAMP; i++) pat[i*SAMP_W +: SAMP_W] = SAMP_W'(i * 1000);
    endtask

    // Sampler model: raises done 20 cycles after a start pulse and records the expected frame.
    initial begin
        smp_done = 1'b0;
        smp_data = '0;
        forever begin
            @(negedge clk_25);
            if (rst_n && smp_start && respond) begin
                repeat (20) @(negedge clk_25);
                smp_data = pat;
                smp_done = 1'b1;
                sb_q.push_back('{data: pat, peak: exp_peak(pat)});
                repeat (3) @(negedge clk_25);
                smp_done = 1'b0;
            end
        end
    end

    // Consumer side: every accepted frame is checked against the oldest expectation.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk_25);
            #2;
            if (rst_n && bus.frm_valid && bus.frm_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_frame", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_frm_data", bus.frm_data, e.data);
                    check("sb_frm_peak", DW'(bus.frm_peak), DW'(e.peak));
                end
            end
        end
    end

    initial begin
        int c0, s, sp, v, t, bad, starts;
        logic [DW-1:0]     d0;
        logic [PEAK_W-1:0] p0;

        rst_n         = 1'b0;
        enable        = 1'b0;
        bus.frm_ready = 1'b0;

        // Reset values and nominal frame cadence.
        do_reset();
        @(negedge clk_25);
        check("rst_smp_start", DW'(smp_start), 0);
        check("rst_frm_valid", DW'(bus.frm_valid), 0);
        check("rst_frm_data", bus.frm_data, 0);
        check("rst_frm_peak", DW'(bus.frm_peak), 0);
        check("rst_drop_cnt", DW'(drop_cnt), 0);
        check("rst_err_timeout", DW'(err_timeout), 0);

        ramp_pattern();
        bus.frm_ready = 1'b1;
        enable = 1'b1;
        c0 = cyc;
        sp = 0;
        for (int k = 0; k < 3; k++) begin
            wait_sig(0, "t1_start", s);
            if (k == 0) check("t1_first_start", DW'(s - c0), 64);
            else        check("t1_period", DW'(s - sp), 64);
            @(negedge clk_25);
            check("t1_start_width", DW'(smp_start), 0);
            wait_sig(1, "t1_valid", v);
            check("t1_latency", DW'(v - s), 37);
            check("t1_peak", DW'(bus.frm_peak), 15000);
            sp = s;
        end

        // Most negative sample saturates.
        pat = '0;
        pat[3*SAMP_W +: SAMP_W] = 18'h20000;
        wait_sig(0, "t2_start", s);
        wait_sig(1, "t2_valid", v);
        check("t2_peak_sat", DW'(bus.frm_peak), 131071);

        // Negative magnitude beats a slightly smaller positive value.
        pat = '0;
        pat[5*SAMP_W +: SAMP_W]  = -18'sd70000;
        pat[10*SAMP_W +: SAMP_W] = 18'sd69999;
        wait_sig(0, "t2b_start", s);
        wait_sig(1, "t2b_valid", v);
        check("t2b_peak_neg", DW'(bus.frm_peak), 70000);
        check("t1_drop_none", DW'(drop_cnt), 0);

        // Consumer stalls 200 cycles.
        do_reset();
        ramp_pattern();
        enable = 1'b1;
        wait_sig(0, "t3_start", s);
        wait_sig(1, "t3_valid", v);
        d0  = bus.frm_data;
        p0  = bus.frm_peak;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_25);
            if (!bus.frm_valid || bus.frm_data !== d0 || bus.frm_peak !== p0) bad++;
        end
        check("t3_hold_stable", DW'(bad), 0);
        check("t3_drop_cnt", DW'(drop_cnt), 3);
        bus.frm_ready = 1'b1;
        @(negedge clk_25);
        check("t3_valid_cleared", DW'(bus.frm_valid), 0);
        wait_sig(0, "t3_restart", t);
        check("t3_next_start", DW'(t - s), 256);

        // Sampler never answers.
        do_reset();
        ramp_pattern();
        respond = 1'b0;
        bus.frm_ready = 1'b1;
        enable = 1'b1;
        wait_sig(0, "t4_start", s);
        wait_sig(2, "t4_err", t);
        check("t4_err_time", DW'(t - s), 101);
        check("t4_state_idle", DW'(dut.state_q), DW'(IDLE));
        respond = 1'b1;
        wait_sig(0, "t4_restart", sp);
        check("t4_restart_time", DW'(sp - s), 128);
        check("t4_drop_cnt", DW'(drop_cnt), 1);
        wait_sig(1, "t4_valid", v);
        check("t4_latency", DW'(v - sp), 37);
        check("t4_err_sticky", DW'(err_timeout), 1);

        // Enable drops while waiting for done.
        do_reset();
        ramp_pattern();
        bus.frm_ready = 1'b1;
        enable = 1'b1;
        wait_sig(0, "t5_start", s);
        repeat (5) @(negedge clk_25);
        enable = 1'b0;
        wait_sig(1, "t5_valid", v);
        check("t5_latency", DW'(v - s), 37);
        starts = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_25);
            if (smp_start) starts++;
        end
        check("t5_no_start", DW'(starts), 0);
        check("t5_cnt_held", DW'(dut.period_cnt), 0);
        enable = 1'b1;
        c0 = cyc;
        wait_sig(0, "t5_reenable", s);
        check("t5_reenable_start", DW'(s - c0), 64);

        // Reset in the middle of SCAN.
        do_reset();
        ramp_pattern();
        respond = 1'b0;
        enable = 1'b1;
        wait_sig(0, "t6_start", s);
        wait_sig(2, "t6_err", t);
        respond = 1'b1;
        wait_sig(0, "t6_start2", s);
        repeat (25) @(negedge clk_25);
        check("t6_pre_err", DW'(err_timeout), 1);
        check("t6_pre_drop", DW'(drop_cnt), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", DW'(bus.frm_valid), 0);
        check("t6_rst_drop", DW'(drop_cnt), 0);
        check("t6_rst_err", DW'(err_timeout), 0);
        check("t6_rst_peak", DW'(bus.frm_peak), 0);
        check("t6_rst_data", bus.frm_data, 0);
        sb_q.delete();
        repeat (2) @(negedge clk_25);
        rst_n = 1'b1;
        c0 = cyc;
        bus.frm_ready = 1'b1;
        wait_sig(0, "t6_restart", s);
        check("t6_restart_time", DW'(s - c0), 64);
        wait_sig(1, "t6_valid", v);
        check("t6_latency", DW'(v - s), 37);
        @(negedge clk_25);
        @(negedge clk_25);
        check("sb_drained", DW'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
